// File: rtl/fetch_pkg.sv
// Shared definitions for the LEGv8 instruction-fetch slice.
//   fetch_state_e    : sequencer states of pc_fetch_unit
//   INSTR_W          : instruction word width
//   RESET_PC_DEFAULT : PC loaded on reset unless overridden
//   TIMEOUT_DEFAULT  : wait-state budget before a fetch is declared lost
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  localparam int          INSTR_W          = 32;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
  localparam int          TIMEOUT_DEFAULT  = 16;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait-state counter for an outstanding instruction fetch.
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart counting from zero (takes priority over en)
//   en       : count one more cycle without a response
//   tc       : counter has reached TIMEOUT-1
// The count saturates at TIMEOUT-1, so tc stays asserted until cleared.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            CW     = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
//   CLK, Reset            : clock, synchronous active-high reset
//   NextPC                : next-PC result, taken on the decode accept cycle
//   CurrentPC             : registered PC (also the fetch address)
//   IMemReq*              : fetch request channel (valid/ready, address)
//   IMemResp*             : read data return (valid only, no backpressure)
//   InstrValid/Ready      : instruction hand-off to decode
//   Instr, InstrPC        : fetched word and the PC it came from
//   Fault, FaultPC        : sticky fault flag and the PC that caused it
//   RetireCount           : number of instructions accepted by decode
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once valid is raised it stays up, with its payload unchanged, until
// that transfer; ready may toggle freely and never depends on valid here.
//
// Every output reads 0 while Reset is asserted.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = fetch_pkg::RESET_PC_DEFAULT,
  parameter int          INSTR_W  = fetch_pkg::INSTR_W,
  parameter int          TIMEOUT  = fetch_pkg::TIMEOUT_DEFAULT
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [63:0]        NextPC,
  output logic [63:0]        CurrentPC,
  output logic               IMemReqValid,
  input  logic               IMemReqReady,
  output logic [63:0]        IMemReqAddr,
  input  logic               IMemRespValid,
  input  logic [INSTR_W-1:0] IMemRespData,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [INSTR_W-1:0] Instr,
  output logic [63:0]        InstrPC,
  output logic               Fault,
  output logic [63:0]        FaultPC,
  output logic [31:0]        RetireCount
);

  import fetch_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [63:0]        instr_pc_q, instr_pc_d;
  logic [63:0]        fault_pc_q, fault_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        retire_q, retire_d;

  logic misaligned;
  logic req_fire;
  logic ctr_en;
  logic ctr_tc;

  // A misaligned PC is caught before any request goes out.
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign req_fire   = (state_q == S_REQ) && !misaligned && IMemReqReady;
  assign ctr_en     = (state_q == S_WAIT) && !IMemRespValid;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk (CLK),
    .rst (Reset),
    .clr (req_fire),
    .en  (ctr_en),
    .tc  (ctr_tc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    fault_pc_d = fault_pc_q;
    instr_d    = instr_q;
    retire_d   = retire_q;
    case (state_q)
      S_REQ: begin
        if (misaligned) begin
          state_d    = S_FAULT;
          fault_pc_d = pc_q;
        end else if (IMemReqReady) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Response beats timeout when both happen in the same cycle.
        if (IMemRespValid) begin
          instr_d    = IMemRespData;
          instr_pc_d = pc_q;
          state_d    = S_HOLD;
        end else if (ctr_tc) begin
          state_d    = S_FAULT;
          fault_pc_d = pc_q;
        end
      end
      S_HOLD: begin
        if (InstrReady) begin
          pc_d     = NextPC;
          retire_d = retire_q + 32'd1;
          state_d  = S_REQ;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_pc_q <= '0;
      fault_pc_q <= '0;
      instr_q    <= '0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      fault_pc_q <= fault_pc_d;
      instr_q    <= instr_d;
      retire_q   <= retire_d;
    end
  end

  assign CurrentPC    = Reset ? 64'h0 : pc_q;
  assign IMemReqAddr  = Reset ? 64'h0 : pc_q;
  assign IMemReqValid = !Reset && (state_q == S_REQ) && !misaligned;
  assign InstrValid   = !Reset && (state_q == S_HOLD);
  assign Instr        = Reset ? '0 : instr_q;
  assign InstrPC      = Reset ? 64'h0 : instr_pc_q;
  assign Fault        = !Reset && (state_q == S_FAULT);
  assign FaultPC      = Reset ? 64'h0 : fault_pc_q;
  assign RetireCount  = Reset ? 32'h0 : retire_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int          TIMEOUT  = 16;
  localparam logic [63:0] RESET_PC = 64'h0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] next_pc;
  logic        req_ready, resp_valid, instr_ready;
  logic [31:0] resp_data;
  logic [63:0] cur_pc, req_addr, instr_pc, fault_pc;
  logic        req_valid, instr_valid, fault;
  logic [31:0] instr, retire;

  pc_fetch_unit #(
    .RESET_PC (RESET_PC),
    .INSTR_W  (32),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK           (clk),
    .Reset         (rst),
    .NextPC        (next_pc),
    .CurrentPC     (cur_pc),
    .IMemReqValid  (req_valid),
    .IMemReqReady  (req_ready),
    .IMemReqAddr   (req_addr),
    .IMemRespValid (resp_valid),
    .IMemRespData  (resp_data),
    .InstrValid    (instr_valid),
    .InstrReady    (instr_ready),
    .Instr         (instr),
    .InstrPC       (instr_pc),
    .Fault         (fault),
    .FaultPC       (fault_pc),
    .RetireCount   (retire)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  // Transaction-level reference: PC, retired count, fault, one outstanding
  // fetch at most, and the instruction waiting for decode in exp_q.
  logic [63:0] m_pc;
  logic [31:0] m_retire;
  logic        m_fault;
  logic [63:0] m_fault_pc;
  logic        m_pend;
  int          m_delay, m_wait;
  logic [31:0] exp_q[$];

  // Stimulus policy knobs.
  int          p_rr, p_ir, p_max_delay, p_jump;
  logic        p_drop, p_stray, force_resp;
  logic        ov_valid, br_en;
  logic [63:0] ov_pc, br_from, br_to;

  // Log of decode accepts.
  logic [63:0] log_pc[$];
  int          log_cyc[$];
  int          cyc;
  int          misreq;

  task automatic model_reset();
    m_pc = RESET_PC; m_retire = '0; m_fault = 1'b0; m_fault_pc = '0;
    m_pend = 1'b0; m_delay = 0; m_wait = 0; exp_q.delete(); cyc = 0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick(input logic r);
    logic ex_req, ex_iv, acc, resp;
    rst         = r;
    ex_req      = !m_fault && !m_pend && (exp_q.size() == 0) && (m_pc[1:0] == 2'b00);
    ex_iv       = !m_fault && (exp_q.size() != 0);
    req_ready   = ($urandom_range(1, 100) <= p_rr);
    instr_ready = ($urandom_range(1, 100) <= p_ir);
    acc         = !r && ex_iv && instr_ready;
    if (acc) begin
      if (ov_valid)                             next_pc = ov_pc;
      else if (br_en && m_pc == br_from)        next_pc = br_to;
      else if ($urandom_range(1, 100) <= p_jump) next_pc = {$urandom(), $urandom()} & ~64'h3;
      else                                      next_pc = m_pc + 64'd4;
    end else begin
      next_pc = {$urandom(), $urandom()};
    end
    resp      = 1'b0;
    resp_data = $urandom();
    if (m_pend && !p_drop && m_delay == 0) begin
      resp      = 1'b1;
      resp_data = mem_word(m_pc);
    end else if (!m_pend && (force_resp || (p_stray && $urandom_range(0, 3) == 0))) begin
      resp = 1'b1;
    end
    resp_valid = resp;
    force_resp = 1'b0;
    #1;
    if (r) begin
      check_eq("rst_req_valid", req_valid, 0);
      check_eq("rst_req_addr", req_addr, 0);
      check_eq("rst_cur_pc", cur_pc, 0);
      check_eq("rst_instr_valid", instr_valid, 0);
      check_eq("rst_instr", instr, 0);
      check_eq("rst_instr_pc", instr_pc, 0);
      check_eq("rst_fault", fault, 0);
      check_eq("rst_fault_pc", fault_pc, 0);
      check_eq("rst_retire", retire, 0);
      model_reset();
    end else begin
      if (req_valid && req_addr[1:0] != 2'b00) misreq++;
      check_eq("req_valid", req_valid, ex_req);
      check_eq("req_addr", req_addr, m_pc);
      check_eq("cur_pc", cur_pc, m_pc);
      check_eq("instr_valid", instr_valid, ex_iv);
      if (ex_iv) begin
        check_eq("instr", instr, exp_q[0]);
        check_eq("instr_pc", instr_pc, m_pc);
      end
      check_eq("retire", retire, m_retire);
      check_eq("fault", fault, m_fault);
      check_eq("fault_pc", fault_pc, m_fault_pc);
      cyc++;
      if (!m_fault) begin
        if (m_pend) begin
          if (resp) begin
            exp_q.push_back(mem_word(m_pc));
            m_pend = 1'b0;
          end else begin
            m_wait++;
            if (m_delay > 0) m_delay--;
            if (m_wait == TIMEOUT) begin
              m_fault = 1'b1; m_fault_pc = m_pc; m_pend = 1'b0;
            end
          end
        end else if (exp_q.size() != 0) begin
          if (instr_ready) begin
            log_pc.push_back(m_pc);
            log_cyc.push_back(cyc);
            void'(exp_q.pop_front());
            m_retire = m_retire + 32'd1;
            m_pc     = next_pc;
            ov_valid = 1'b0;
          end
        end else if (m_pc[1:0] != 2'b00) begin
          m_fault = 1'b1; m_fault_pc = m_pc;
        end else if (req_ready) begin
          m_pend  = 1'b1;
          m_wait  = 0;
          m_delay = $urandom_range(0, p_max_delay);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick(1'b1);
    tick(1'b1);
  endtask

  // ---------------- test sequence ----------------
  logic [63:0] cap_pc;
  logic [31:0] cap_ret;
  logic        found;

  initial begin
    rst = 1'b1; next_pc = '0; req_ready = 1'b0; resp_valid = 1'b0;
    instr_ready = 1'b0; resp_data = '0;
    p_rr = 100; p_ir = 100; p_max_delay = 0; p_jump = 0;
    p_drop = 1'b0; p_stray = 1'b0; force_resp = 1'b0;
    ov_valid = 1'b0; ov_pc = '0; br_en = 1'b0; br_from = '0; br_to = '0;
    misreq = 0;
    model_reset();
    @(negedge clk);

    // Reset, then sequential zero-wait fetch: accepts at cycles 3,6,9,12.
    do_reset();
    log_pc.delete(); log_cyc.delete();
    repeat (12) tick(1'b0);
    check_eq("seq_retire", retire, 4);
    check_eq("seq_count", log_pc.size(), 4);
    for (int i = 0; i < log_pc.size() && i < 4; i++) begin
      check_eq("seq_pc", log_pc[i], 64'(4 * i));
      check_eq("seq_cycle", log_cyc[i], 3 * (i + 1));
    end

    // Branch: accept of PC 0x8 with NextPC=0x40.
    do_reset();
    br_en = 1'b1; br_from = 64'h8; br_to = 64'h40;
    log_pc.delete(); log_cyc.delete();
    repeat (15) tick(1'b0);
    br_en = 1'b0;
    check_eq("br_count", log_pc.size(), 5);
    if (log_pc.size() >= 5) begin
      check_eq("br_pc3", log_pc[3], 64'h40);
      check_eq("br_pc4", log_pc[4], 64'h44);
    end

    // Backpressure on the request, then on decode.
    p_rr = 0;
    cap_pc = m_pc; cap_ret = m_retire;
    repeat (5) tick(1'b0);
    check_eq("bp_req_valid", req_valid, 1);
    check_eq("bp_req_addr", req_addr, cap_pc);
    check_eq("bp_retire_a", retire, cap_ret);
    p_rr = 100; p_ir = 0;
    for (int i = 0; i < 10 && exp_q.size() == 0; i++) tick(1'b0);
    check_eq("bp_hold_reached", instr_valid, 1);
    repeat (4) tick(1'b0);
    check_eq("bp_instr", instr, mem_word(cap_pc));
    check_eq("bp_instr_pc", instr_pc, cap_pc);
    check_eq("bp_retire_b", retire, cap_ret);
    p_ir = 100;

    // Random traffic with stray responses and random jumps.
    p_rr = 70; p_ir = 70; p_max_delay = 4; p_stray = 1'b1; p_jump = 10;
    repeat (400) tick(1'b0);

    // Address wrap at the top of the 64-bit space.
    p_jump = 0; ov_valid = 1'b1; ov_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    log_pc.delete(); log_cyc.delete();
    repeat (100) tick(1'b0);
    found = 1'b0;
    for (int i = 0; i + 1 < log_pc.size(); i++)
      if (log_pc[i] == 64'hFFFF_FFFF_FFFF_FFFC && log_pc[i + 1] == 64'h0) found = 1'b1;
    check_eq("wrap_seen", found, 1);

    // Misaligned NextPC.
    misreq = 0;
    ov_valid = 1'b1; ov_pc = 64'h42;
    for (int i = 0; i < 80 && !m_fault; i++) tick(1'b0);
    repeat (5) tick(1'b0);
    check_eq("mis_fault", fault, 1);
    check_eq("mis_fault_pc", fault_pc, 64'h42);
    check_eq("mis_no_request", misreq, 0);

    // Response timeout after some normal traffic.
    do_reset();
    p_stray = 1'b0; p_rr = 100; p_ir = 100; p_max_delay = 2;
    repeat (10) tick(1'b0);
    p_drop = 1'b1;
    for (int i = 0; i < 60 && !m_fault; i++) tick(1'b0);
    repeat (3) tick(1'b0);
    check_eq("to_fault", fault, 1);
    check_eq("to_fault_pc", fault_pc, m_pc);

    // Reset while a fetch is outstanding; the late response must be ignored.
    do_reset();
    p_max_delay = 0;
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    p_drop = 1'b0;
    force_resp = 1'b1;
    log_pc.delete(); log_cyc.delete();
    repeat (20) tick(1'b0);
    check_eq("rw_fault", fault, 0);
    check_eq("rw_first_pc", (log_pc.size() > 0) ? log_pc[0] : 64'hDEAD, RESET_PC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
